// File: rtl/cdb_arbiter_if.sv
// Producer-side and broadcast-side signals of the common data bus arbiter.
// Lane i of each packed array belongs to producer i (0=ALU, 1=LSB, 2=BRU).
interface cdb_arbiter_if #(
  parameter int NUM_REQ  = 3,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
);
  localparam int SRC_W = (NUM_REQ > 4) ? $clog2(NUM_REQ) : 2;

  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ-1:0][ROB_ID_W-1:0] req_rob_id;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_value;
  logic                             cdb_valid;
  logic [ROB_ID_W-1:0]              cdb_rob_id;
  logic [DATA_W-1:0]                cdb_value;
  logic [SRC_W-1:0]                 cdb_src;

  modport master (
    output req_valid, req_rob_id, req_value,
    input  req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );

  modport slave (
    input  req_valid, req_rob_id, req_value,
    output req_ready, cdb_valid, cdb_rob_id, cdb_value, cdb_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// CDB arbiter: one holding slot per producer, round-robin grant, one
// registered broadcast per cycle. rdy freezes everything; clear flushes slots.
module cdb_slot #(
  parameter int ENT_W = 37
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             i_clear,
  input  logic             i_accept,
  input  logic             i_grant,
  input  logic [ENT_W-1:0] i_ent,
  output logic             o_valid,
  output logic [ENT_W-1:0] o_ent
);
  logic             r_valid;
  logic [ENT_W-1:0] r_ent;

  // accept wins over grant so a slot drained this cycle can refill at once
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_valid <= 1'b0;
      r_ent   <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_accept) begin
      r_valid <= 1'b1;
      r_ent   <= i_ent;
    end else if (i_grant) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_ent   = r_ent;
endmodule

module cdb_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ROB_ID_W = 5,
  parameter int DATA_W   = 32
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          i_rdy,
  input  logic          i_clear,
  cdb_arbiter_if.slave  io_bus
);
  localparam int SRC_W = (NUM_REQ > 4) ? $clog2(NUM_REQ) : 2;

  typedef struct packed {
    logic [ROB_ID_W-1:0] rob_id;
    logic [DATA_W-1:0]   value;
  } ent_t;
  localparam int ENT_W = $bits(ent_t);

  logic                w_arb_en;
  logic [NUM_REQ-1:0]  w_slot_vld;
  logic [NUM_REQ-1:0]  w_grant;
  logic [NUM_REQ-1:0]  w_accept;
  ent_t [NUM_REQ-1:0]  w_slot_ent;
  logic                w_any;
  logic [SRC_W-1:0]    w_gidx;

  logic                r_cdb_valid;
  logic [ROB_ID_W-1:0] r_cdb_rob_id;
  logic [DATA_W-1:0]   r_cdb_value;
  logic [SRC_W-1:0]    r_cdb_src;
  logic [SRC_W-1:0]    r_rr_ptr;

  assign w_arb_en = i_rdy & ~i_clear;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      ent_t w_in;
      assign w_in = {io_bus.req_rob_id[gi], io_bus.req_value[gi]};

      cdb_slot #(.ENT_W(ENT_W)) u_slot (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .i_clear  (i_clear),
        .i_accept (w_accept[gi]),
        .i_grant  (w_grant[gi]),
        .i_ent    (w_in),
        .o_valid  (w_slot_vld[gi]),
        .o_ent    (w_slot_ent[gi])
      );
    end
  endgenerate

  function automatic logic [SRC_W-1:0] rot(input logic [SRC_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return SRC_W'(s);
  endfunction

  // first occupied slot at or after rr_ptr, wrapping
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_any   = 1'b0;
    if (w_arb_en) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        if (!w_any && w_slot_vld[rot(r_rr_ptr, off)]) begin
          w_any                        = 1'b1;
          w_grant[rot(r_rr_ptr, off)]  = 1'b1;
          w_gidx                       = rot(r_rr_ptr, off);
        end
      end
    end
  end

  assign io_bus.req_ready = {NUM_REQ{w_arb_en}} & (~w_slot_vld | w_grant);
  assign w_accept         = io_bus.req_valid & io_bus.req_ready;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cdb_valid  <= 1'b0;
      r_cdb_rob_id <= '0;
      r_cdb_value  <= '0;
      r_cdb_src    <= '0;
      r_rr_ptr     <= '0;
    end else if (i_clear) begin
      r_cdb_valid <= 1'b0;
    end else if (i_rdy) begin
      r_cdb_valid <= w_any;
      if (w_any) begin
        r_cdb_rob_id <= w_slot_ent[w_gidx].rob_id;
        r_cdb_value  <= w_slot_ent[w_gidx].value;
        r_cdb_src    <= w_gidx;
        r_rr_ptr     <= (w_gidx == SRC_W'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
      end
    end
  end

  assign io_bus.cdb_valid  = r_cdb_valid;
  assign io_bus.cdb_rob_id = r_cdb_rob_id;
  assign io_bus.cdb_value  = r_cdb_value;
  assign io_bus.cdb_src    = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus a random run, all checked
// against a slot/queue-level reference model of the arbitration rules.
module tb_cdb_arbiter;
  localparam int N = 3, TW = 5, DW = 32;

  logic clk = 1'b0;
  logic rst, rdy, clr;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N), .ROB_ID_W(TW), .DATA_W(DW)) bus();
  cdb_arbiter #(.NUM_REQ(N), .ROB_ID_W(TW), .DATA_W(DW)) dut (
    .clk_in(clk), .rst_in(rst), .i_rdy(rdy), .i_clear(clr), .io_bus(bus)
  );

  int n_cmp = 0, n_err = 0;

  // reference model state
  bit             m_sv[N];
  logic [TW-1:0]  m_st[N];
  logic [DW-1:0]  m_sd[N];
  int             m_ptr;
  bit             m_cv;
  logic [TW-1:0]  m_tag;
  logic [DW-1:0]  m_val;
  int             m_src;
  logic [N-1:0]   obs_rdy, exp_rdy;

  function automatic logic [39:0] exp_cdb();
    return {m_cv, m_tag, m_val, 2'(m_src)};
  endfunction

  function automatic logic [39:0] obs_cdb();
    return {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_value, bus.cdb_src};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < N; i++) begin m_sv[i] = 0; m_st[i] = '0; m_sd[i] = '0; end
    m_ptr = 0; m_cv = 0; m_tag = '0; m_val = '0; m_src = 0;
  endtask

  function automatic int m_winner(input bit r, input bit c);
    if (!r || c) return -1;
    for (int j = 0; j < N; j++)
      if (m_sv[(m_ptr + j) % N]) return (m_ptr + j) % N;
    return -1;
  endfunction

  // drive one cycle, sample ready before the edge, advance model past the edge
  task automatic step(input logic [N-1:0] v, input logic [N-1:0][TW-1:0] t,
                      input logic [N-1:0][DW-1:0] d, input bit r, input bit c);
    int w;
    logic [N-1:0] acc;
    bus.req_valid = v; bus.req_rob_id = t; bus.req_value = d; rdy = r; clr = c;
    #1;
    w = m_winner(r, c);
    for (int i = 0; i < N; i++) exp_rdy[i] = r && !c && (!m_sv[i] || i == w);
    obs_rdy = bus.req_ready;
    @(posedge clk); #1;
    acc = v & exp_rdy;
    if (c) begin
      for (int i = 0; i < N; i++) m_sv[i] = 0;
      m_cv = 0;
    end else if (r) begin
      if (w >= 0) begin
        m_cv = 1; m_tag = m_st[w]; m_val = m_sd[w]; m_src = w;
        m_ptr = (w + 1) % N; m_sv[w] = 0;
      end else m_cv = 0;
      for (int i = 0; i < N; i++)
        if (acc[i]) begin m_sv[i] = 1; m_st[i] = t[i]; m_sd[i] = d[i]; end
    end
  endtask

  task automatic offer(input logic [N-1:0] v, input int tbase, input bit r, input bit c);
    logic [N-1:0][TW-1:0] t;
    logic [N-1:0][DW-1:0] d;
    for (int i = 0; i < N; i++) begin t[i] = TW'(tbase + i); d[i] = $urandom; end
    step(v, t, d, r, c);
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    m_reset();
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_err++; $display("FAIL rst_async cdb_valid got %b exp 0", bus.cdb_valid); end
    n_cmp++; if (bus.req_ready !== 3'b111) begin n_err++; $display("FAIL rst_async ready got %b exp 111", bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clr = 1'b0;
    bus.req_valid = '0; bus.req_rob_id = '0; bus.req_value = '0;
    m_reset();
    #2;
    n_cmp++; if (obs_cdb() !== 40'h0) begin n_err++; $display("FAIL reset cdb got %h exp %h", obs_cdb(), 40'h0); end
    n_cmp++; if (bus.req_ready !== 3'b111) begin n_err++; $display("FAIL reset ready got %b exp 111", bus.req_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [N-1:0][TW-1:0] t;
    logic [N-1:0][DW-1:0] d;
    t = '0; d = '0; t[0] = 5'd5; d[0] = 32'h11;
    step(3'b001, t, d, 1, 0);
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_err++; $display("FAIL single_nobypass cdb_valid got %b exp 0", bus.cdb_valid); end
    offer('0, 0, 1, 0);
    n_cmp++; if (obs_cdb() !== {1'b1, 5'd5, 32'h11, 2'd0}) begin n_err++; $display("FAIL single_bcast got %h exp %h", obs_cdb(), {1'b1, 5'd5, 32'h11, 2'd0}); end
    offer('0, 0, 1, 0);
    n_cmp++; if (obs_cdb() !== exp_cdb()) begin n_err++; $display("FAIL single_pulse got %h exp %h", obs_cdb(), exp_cdb()); end
  endtask

  task automatic test_contention();
    pulse_reset();
    offer(3'b111, 1, 1, 0);
    for (int k = 0; k < N; k++) begin
      offer('0, 0, 1, 0);
      n_cmp++; if (bus.cdb_src !== 2'(k) || bus.cdb_rob_id !== TW'(k + 1) || obs_cdb() !== exp_cdb())
        begin n_err++; $display("FAIL contention_%0d got %h exp src %0d tag %0d model %h", k, obs_cdb(), k, k + 1, exp_cdb()); end
    end
    // rr_ptr should be back at 0: a lone request on slot 2 then 0 keeps order 0 first
    offer(3'b101, 9, 1, 0);
    offer('0, 0, 1, 0);
    n_cmp++; if (bus.cdb_src !== 2'd0 || obs_cdb() !== exp_cdb()) begin n_err++; $display("FAIL contention_wrap got %h exp src 0 model %h", obs_cdb(), exp_cdb()); end
    offer('0, 0, 1, 0);
    offer('0, 0, 1, 0);
  endtask

  task automatic test_streaming();
    for (int s = 0; s <= 8; s++) begin
      offer((s < 8) ? 3'b010 : 3'b000, s - 1, 1, 0);
      if (s < 8) begin
        n_cmp++; if (obs_rdy[1] !== 1'b1) begin n_err++; $display("FAIL stream_ready_%0d got %b exp 1", s, obs_rdy[1]); end
      end
      if (s >= 1) begin
        n_cmp++; if (obs_cdb() !== exp_cdb() || bus.cdb_valid !== 1'b1 || bus.cdb_src !== 2'd1 || bus.cdb_rob_id !== TW'(s - 1))
          begin n_err++; $display("FAIL stream_%0d got %h exp tag %0d model %h", s, obs_cdb(), s - 1, exp_cdb()); end
      end
    end
  endtask

  task automatic test_rotation();
    int order[4] = '{2, 0, 2, 0};
    offer(3'b001, 10, 1, 0);
    offer(3'b101, 13, 1, 0);
    n_cmp++; if (bus.cdb_src !== 2'd0 || obs_cdb() !== exp_cdb()) begin n_err++; $display("FAIL rot_setup got %h exp src 0 model %h", obs_cdb(), exp_cdb()); end
    for (int k = 0; k < 4; k++) begin
      offer(3'b101, 16 + 3 * k, 1, 0);
      n_cmp++; if (bus.cdb_src !== 2'(order[k]) || bus.cdb_valid !== 1'b1 || obs_cdb() !== exp_cdb())
        begin n_err++; $display("FAIL rot_%0d got %h exp src %0d model %h", k, obs_cdb(), order[k], exp_cdb()); end
      n_cmp++; if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL rot_ready_%0d got %b exp %b", k, obs_rdy, exp_rdy); end
    end
  endtask

  task automatic test_clear();
    offer(3'b111, 20, 1, 0);
    offer(3'b111, 23, 1, 0);
    offer(3'b111, 26, 1, 1);
    n_cmp++; if (obs_rdy !== 3'b000) begin n_err++; $display("FAIL clear_ready got %b exp 000", obs_rdy); end
    n_cmp++; if (bus.cdb_valid !== 1'b0) begin n_err++; $display("FAIL clear_cdb got %b exp 0", bus.cdb_valid); end
    for (int k = 0; k < 3; k++) begin
      offer('0, 0, 1, 0);
      n_cmp++; if (bus.cdb_valid !== 1'b0 || obs_rdy !== 3'b111) begin n_err++; $display("FAIL clear_empty_%0d valid %b ready %b exp 0 111", k, bus.cdb_valid, obs_rdy); end
    end
  endtask

  task automatic test_freeze();
    offer(3'b111, 0, 1, 0);
    offer(3'b111, 3, 1, 0);
    for (int k = 0; k < 4; k++) begin
      offer(3'b111, 8, 0, 0);
      n_cmp++; if (obs_rdy !== 3'b000) begin n_err++; $display("FAIL freeze_ready_%0d got %b exp 000", k, obs_rdy); end
      n_cmp++; if (obs_cdb() !== exp_cdb()) begin n_err++; $display("FAIL freeze_hold_%0d got %h exp %h", k, obs_cdb(), exp_cdb()); end
    end
    for (int k = 0; k < 4; k++) begin
      offer('0, 0, 1, 0);
      n_cmp++; if (obs_cdb() !== exp_cdb()) begin n_err++; $display("FAIL resume_%0d got %h exp %h", k, obs_cdb(), exp_cdb()); end
    end
  endtask

  task automatic test_reset_mid();
    offer(3'b111, 12, 1, 0);
    offer(3'b000, 0, 1, 0);
    n_cmp++; if (bus.cdb_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre valid got %b exp 1", bus.cdb_valid); end
    pulse_reset();
    offer('0, 0, 1, 0);
    n_cmp++; if (obs_cdb() !== 40'h0 || obs_rdy !== 3'b111) begin n_err++; $display("FAIL midrst_empty got %h ready %b exp 0 111", obs_cdb(), obs_rdy); end
  endtask

  task automatic test_random();
    logic [N-1:0][TW-1:0] t;
    logic [N-1:0][DW-1:0] d;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N; i++) begin t[i] = TW'($urandom); d[i] = $urandom; end
      step(N'($urandom), t, d, $urandom_range(0, 9) != 0, $urandom_range(0, 24) == 0);
      n_cmp++; if (obs_cdb() !== exp_cdb()) begin n_err++; $display("FAIL rand_cdb_%0d got %h exp %h", k, obs_cdb(), exp_cdb()); end
      n_cmp++; if (obs_rdy !== exp_rdy) begin n_err++; $display("FAIL rand_ready_%0d got %b exp %b", k, obs_rdy, exp_rdy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_streaming();
    test_rotation();
    test_clear();
    test_freeze();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
